reg_file_8x16: RTL and testbench

REG_FILE_8X16 -- requirements
Module: reg_file_8x16

---
 rtl/reg_file_8x16_pkg.sv | 21 ++
 rtl/reg_file_8x16_reg_cell.sv | 34 +++
 rtl/reg_file_8x16.sv | 101 ++++++++++
 tb/tb_reg_file_8x16.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_8x16_pkg.sv
// Shared CPU package for the 8-entry register file.
// Holds the default data width, register count, index width and the width
// of the pending-count output, plus a population-count helper.
package reg_file_8x16_pkg;

  localparam int DATA_W   = 16;  // default register / data-port width
  localparam int NUM_REGS = 8;   // R0..R7
  localparam int IDX_W    = 3;   // register index width
  localparam int PCNT_W   = 4;   // enough for 0..7 pending registers

  // Number of set bits in a pending vector.
  function automatic logic [PCNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [PCNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + PCNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/reg_file_8x16_reg_cell.sv
// reg_cell: one WIDTH-bit storage register with load enable and
// asynchronous active-high reset.
// Ports:
//   clk_i  - clock, loads on rising edge
//   rst_i  - asynchronous active-high reset, clears the register
//   en_i   - load enable
//   d_i    - data to load
//   q_o    - current register contents
module reg_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) data_d = d_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_file_8x16.sv
// reg_file_8x16: eight-entry register file (R0 hardwired to zero) with two
// combinational read ports and a pending-writer scoreboard.
// Optional build macro: REGFILE_BYPASS_EN -- when defined, a write-back in
// the current cycle is forwarded to a read port addressing the same register
// and that port's busy flag is forced low.
// Ports:
//   CLK          - clock, all state updates on rising edge
//   RST          - asynchronous active-high reset
//   WE/WA/WD     - write-back enable, index, data (also retires pending[WA])
//   ISSUE/IA     - marks register IA as having an in-flight writer
//   RA/RB        - read indices for ports A/B
//   OUTA/OUTB    - read data for ports A/B
//   BUSYA/BUSYB  - addressed register is pending
//   PCNT         - registered count of pending registers
module reg_file_8x16
  import reg_file_8x16_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [IDX_W-1:0]  WA,
  input  logic [WIDTH-1:0]  WD,
  input  logic              ISSUE,
  input  logic [IDX_W-1:0]  IA,
  input  logic [IDX_W-1:0]  RA,
  input  logic [IDX_W-1:0]  RB,
  output logic [WIDTH-1:0]  OUTA,
  output logic [WIDTH-1:0]  OUTB,
  output logic              BUSYA,
  output logic              BUSYB,
  output logic [PCNT_W-1:0] PCNT
);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [PCNT_W-1:0]   pcnt_q;
  logic                wr_ok;
  logic                iss_ok;

  assign wr_ok  = WE && (WA != '0);
  assign iss_ok = ISSUE && (IA != '0);

  // ---------------- storage ----------------
  assign regs[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cell
    logic cell_en;
    assign cell_en = wr_ok && (WA == IDX_W'(g));
    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk_i (CLK),
      .rst_i (RST),
      .en_i  (cell_en),
      .d_i   (WD),
      .q_o   (regs[g])
    );
  end

  // ---------------- scoreboard ----------------
  // Retire first, then set: an issue to the same index as a write-back
  // leaves the bit set because the new writer is still outstanding.
  always_comb begin
    pending_d = pending_q;
    if (wr_ok)  pending_d[WA] = 1'b0;
    if (iss_ok) pending_d[IA] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_q <= '0;
      pcnt_q    <= '0;
    end else begin
      pending_q <= pending_d;
      pcnt_q    <= popcount(pending_d);
    end
  end

  assign PCNT = pcnt_q;

  // ---------------- read ports ----------------
`ifdef REGFILE_BYPASS_EN
  // Forwarding is gated by RST so reset always presents zero outputs.
  logic hit_a;
  logic hit_b;
  assign hit_a = wr_ok && !RST && (WA == RA);
  assign hit_b = wr_ok && !RST && (WA == RB);
  assign OUTA  = hit_a ? WD : regs[RA];
  assign OUTB  = hit_b ? WD : regs[RB];
  assign BUSYA = pending_q[RA] && !hit_a;
  assign BUSYB = pending_q[RB] && !hit_b;
`else
  assign OUTA  = regs[RA];
  assign OUTB  = regs[RB];
  assign BUSYA = pending_q[RA];
  assign BUSYB = pending_q[RB];
`endif

endmodule

// File: tb/tb_reg_file_8x16.sv
module tb_reg_file_8x16;
  import reg_file_8x16_pkg::*;

  localparam int W = DATA_W;

  logic              CLK;
  logic              RST;
  logic              WE;
  logic [IDX_W-1:0]  WA;
  logic [W-1:0]      WD;
  logic              ISSUE;
  logic [IDX_W-1:0]  IA;
  logic [IDX_W-1:0]  RA;
  logic [IDX_W-1:0]  RB;
  logic [W-1:0]      OUTA;
  logic [W-1:0]      OUTB;
  logic              BUSYA;
  logic              BUSYB;
  logic [PCNT_W-1:0] PCNT;

  int n_cmp;
  int n_fail;

  reg_file_8x16 #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .WE    (WE),
    .WA    (WA),
    .WD    (WD),
    .ISSUE (ISSUE),
    .IA    (IA),
    .RA    (RA),
    .RB    (RB),
    .OUTA  (OUTA),
    .OUTB  (OUTB),
    .BUSYA (BUSYA),
    .BUSYB (BUSYB),
    .PCNT  (PCNT)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- drivers ----------------
  // Advance one rising edge; return 1 time unit after it.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WE = 1'b0; WA = '0; WD = '0; ISSUE = 1'b0; IA = '0;
  endtask

  task automatic drive_write(input logic [IDX_W-1:0] a, input logic [W-1:0] d);
    WE = 1'b1; WA = a; WD = d;
  endtask

  task automatic drive_issue(input logic [IDX_W-1:0] a);
    ISSUE = 1'b1; IA = a;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset_state();
    RST = 1'b1; idle(); RA = 3'd5; RB = 3'd7;
    #2;
    n_cmp++; if (OUTA !== 16'h0000) begin n_fail++; $display("FAIL rst_outa got=%h exp=%h", OUTA, 16'h0000); end
    n_cmp++; if (OUTB !== 16'h0000) begin n_fail++; $display("FAIL rst_outb got=%h exp=%h", OUTB, 16'h0000); end
    n_cmp++; if (PCNT !== 4'd0) begin n_fail++; $display("FAIL rst_pcnt got=%0d exp=0", PCNT); end
    n_cmp++; if ({BUSYA, BUSYB} !== 2'b00) begin n_fail++; $display("FAIL rst_busy got=%b exp=00", {BUSYA, BUSYB}); end
    cyc(); cyc();
    RST = 1'b0;
    cyc();
  endtask

  task automatic test_write_read();
    drive_write(3'd5, 16'hBEEF); RA = 3'd5;
    cyc(); idle();
    #1;
    n_cmp++; if (OUTA !== 16'hBEEF) begin n_fail++; $display("FAIL wr_r5 got=%h exp=%h", OUTA, 16'hBEEF); end
    drive_write(3'd7, 16'h0F0F); RA = 3'd7; RB = 3'd5;
    cyc(); idle();
    #1;
    n_cmp++; if (OUTA !== 16'h0F0F) begin n_fail++; $display("FAIL wr_r7 got=%h exp=%h", OUTA, 16'h0F0F); end
    n_cmp++; if (OUTB !== 16'hBEEF) begin n_fail++; $display("FAIL rd_b_r5 got=%h exp=%h", OUTB, 16'hBEEF); end
    n_cmp++; if (PCNT !== 4'd0) begin n_fail++; $display("FAIL wr_nonpend_pcnt got=%0d exp=0", PCNT); end
  endtask

  task automatic test_r0();
    drive_write(3'd0, 16'hFFFF); drive_issue(3'd0); RB = 3'd0;
    #1;
    n_cmp++; if (OUTB !== 16'h0000) begin n_fail++; $display("FAIL r0_same_cyc got=%h exp=%h", OUTB, 16'h0000); end
    cyc(); idle();
    #1;
    n_cmp++; if (OUTB !== 16'h0000) begin n_fail++; $display("FAIL r0_after got=%h exp=%h", OUTB, 16'h0000); end
    n_cmp++; if (BUSYB !== 1'b0) begin n_fail++; $display("FAIL r0_busy got=%b exp=0", BUSYB); end
    n_cmp++; if (PCNT !== 4'd0) begin n_fail++; $display("FAIL r0_pcnt got=%0d exp=0", PCNT); end
  endtask

  task automatic test_scoreboard();
    drive_issue(3'd2); cyc(); idle();
    drive_issue(3'd4); cyc(); idle();
    RA = 3'd2; RB = 3'd4;
    #1;
    n_cmp++; if (PCNT !== 4'd2) begin n_fail++; $display("FAIL sb_pcnt2 got=%0d exp=2", PCNT); end
    n_cmp++; if (BUSYA !== 1'b1) begin n_fail++; $display("FAIL sb_busya2 got=%b exp=1", BUSYA); end
    n_cmp++; if (BUSYB !== 1'b1) begin n_fail++; $display("FAIL sb_busyb4 got=%b exp=1", BUSYB); end
    drive_write(3'd2, 16'h2222); cyc(); idle();
    #1;
    n_cmp++; if (PCNT !== 4'd1) begin n_fail++; $display("FAIL sb_pcnt1 got=%0d exp=1", PCNT); end
    n_cmp++; if (BUSYA !== 1'b0) begin n_fail++; $display("FAIL sb_busya_clr got=%b exp=0", BUSYA); end
    n_cmp++; if (OUTA !== 16'h2222) begin n_fail++; $display("FAIL sb_r2 got=%h exp=%h", OUTA, 16'h2222); end
  endtask

  task automatic test_same_index();
    // pending = {4}; add 6 -> {4,6}
    drive_issue(3'd6); cyc(); idle();
    drive_issue(3'd6); drive_write(3'd6, 16'h6666); cyc(); idle();
    RA = 3'd6;
    #1;
    n_cmp++; if (BUSYA !== 1'b1) begin n_fail++; $display("FAIL same_busy6 got=%b exp=1", BUSYA); end
    n_cmp++; if (OUTA !== 16'h6666) begin n_fail++; $display("FAIL same_r6 got=%h exp=%h", OUTA, 16'h6666); end
    n_cmp++; if (PCNT !== 4'd2) begin n_fail++; $display("FAIL same_pcnt got=%0d exp=2", PCNT); end
  endtask

  task automatic test_diff_index();
    // pending {4,6}: retire 4 while issuing 3 -> {3,6}
    drive_issue(3'd3); drive_write(3'd4, 16'h4444); cyc(); idle();
    RA = 3'd3; RB = 3'd4;
    #1;
    n_cmp++; if ({BUSYA, BUSYB} !== 2'b10) begin n_fail++; $display("FAIL diff_busy got=%b exp=10", {BUSYA, BUSYB}); end
    n_cmp++; if (OUTB !== 16'h4444) begin n_fail++; $display("FAIL diff_r4 got=%h exp=%h", OUTB, 16'h4444); end
    n_cmp++; if (PCNT !== 4'd2) begin n_fail++; $display("FAIL diff_pcnt got=%0d exp=2", PCNT); end
  endtask

  task automatic test_bypass();
    logic [W-1:0] exp_same;
    logic         exp_busy;
`ifdef REGFILE_BYPASS_EN
    exp_same = 16'h00AA; exp_busy = 1'b0;
`else
    exp_same = 16'h0011; exp_busy = 1'b1;
`endif
    drive_write(3'd1, 16'h0011); cyc(); idle();
    drive_issue(3'd1); cyc(); idle();   // pending {1,3,6}
    drive_write(3'd1, 16'h00AA); RA = 3'd1; RB = 3'd1;
    #1;
    n_cmp++; if (OUTA !== exp_same) begin n_fail++; $display("FAIL byp_outa got=%h exp=%h", OUTA, exp_same); end
    n_cmp++; if (OUTB !== exp_same) begin n_fail++; $display("FAIL byp_outb got=%h exp=%h", OUTB, exp_same); end
    n_cmp++; if (BUSYA !== exp_busy) begin n_fail++; $display("FAIL byp_busya got=%b exp=%b", BUSYA, exp_busy); end
    cyc(); idle();
    #1;
    n_cmp++; if (OUTA !== 16'h00AA) begin n_fail++; $display("FAIL byp_next got=%h exp=%h", OUTA, 16'h00AA); end
    n_cmp++; if (BUSYA !== 1'b0) begin n_fail++; $display("FAIL byp_busy_next got=%b exp=0", BUSYA); end
    n_cmp++; if (PCNT !== 4'd2) begin n_fail++; $display("FAIL byp_pcnt got=%0d exp=2", PCNT); end
  endtask

  task automatic test_mid_reset();
    // pending {3,6}; write R3 retires it -> {6}
    drive_write(3'd3, 16'h1234); cyc(); idle();
    RA = 3'd3; RB = 3'd6;
    #1;
    n_cmp++; if (OUTA !== 16'h1234) begin n_fail++; $display("FAIL mr_pre got=%h exp=%h", OUTA, 16'h1234); end
    n_cmp++; if (PCNT !== 4'd1) begin n_fail++; $display("FAIL mr_pre_pcnt got=%0d exp=1", PCNT); end
    // Assert reset mid-cycle with a write and issue also presented.
    drive_write(3'd5, 16'h5555); drive_issue(3'd5);
    #1 RST = 1'b1;
    #1;
    n_cmp++; if (OUTA !== 16'h0000) begin n_fail++; $display("FAIL mr_outa got=%h exp=%h", OUTA, 16'h0000); end
    n_cmp++; if (PCNT !== 4'd0) begin n_fail++; $display("FAIL mr_pcnt got=%0d exp=0", PCNT); end
    n_cmp++; if (BUSYB !== 1'b0) begin n_fail++; $display("FAIL mr_busyb got=%b exp=0", BUSYB); end
    RA = 3'd5;
    #1;
    n_cmp++; if (OUTA !== 16'h0000) begin n_fail++; $display("FAIL mr_r5_during got=%h exp=%h", OUTA, 16'h0000); end
    cyc();
    idle(); RST = 1'b0;
    cyc();
    RB = 3'd7;
    #1;
    n_cmp++; if (OUTA !== 16'h0000) begin n_fail++; $display("FAIL mr_r5_after got=%h exp=%h", OUTA, 16'h0000); end
    n_cmp++; if (OUTB !== 16'h0000) begin n_fail++; $display("FAIL mr_r7_after got=%h exp=%h", OUTB, 16'h0000); end
    n_cmp++; if ({BUSYA, PCNT} !== 5'd0) begin n_fail++; $display("FAIL mr_pend_after got=%b/%0d exp=0/0", BUSYA, PCNT); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    RA = '0; RB = '0;
    test_reset_state();
    test_write_read();
    test_r0();
    test_scoreboard();
    test_same_index();
    test_diff_index();
    test_bypass();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
